calc_sequencer: RTL
===================

CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, instruction buffer depth in entries; power of two, 2 to 16.
REQ-002 Clk  input  1  rising-edge clock.
REQ-003 Rst_n  input  1  asynchronous active-low reset.
REQ-004 Inst_valid  input  1  an instruction word is offered.
REQ-005 Inst  input  24  instruction word: [23:20] Ctrl, [19] Sel, [18] Wen, [17:15] RW, [14:12] RX, [11:9] RY, [8] Cap, [7:0] Imm.
REQ-006 Inst_ready  output  1  FIFO not full.
REQ-007 Halt  input  1  level; pause issue.
REQ-008 Step  input  1  one-cycle pulse; issue one instruction while paused.
REQ-009 WEN  output  1  register-file write enable to the calculator datapath.
REQ-010 RW, RX, RY  output  3 each  register addresses.
REQ-011 Sel  output  1  ALU X-operand select (1 = busX, 0 = DataIn).
REQ-012 Ctrl  output  4  ALU opcode.
REQ-013 DataIn  output  8  immediate operand.
REQ-014 busY  input  8  datapath busY read-back.
REQ-015 Carry  input  1  ALU carry read-back.
REQ-016 Res_valid  output  1  one-cycle pulse; captured result is valid.
REQ-017 Res_data  output  8  captured busY.
REQ-018 Res_carry  output  1  captured Carry.
REQ-019 Issue_cnt  output  8  count of issued instructions; wraps at 255 to 0.
REQ-020 Busy  output  1  FIFO non-empty or state not IDLE.

Function
REQ-021 Handshake: an instruction SHALL be accepted when Inst_valid and Inst_ready are both high at a rising edge.
REQ-022 Inst_ready SHALL be high exactly when the FIFO occupancy is less than FIFO_DEPTH.
REQ-023 Accepted instructions SHALL issue in order.
REQ-024 States: IDLE, RUN, PAUSED.
REQ-025 IDLE SHALL go to RUN when the FIFO is non-empty and Halt = 0, and SHALL go to PAUSED when Halt = 1.
REQ-026 RUN SHALL issue one instruction per cycle while the FIFO is non-empty; it SHALL go to IDLE when the FIFO is empty and to PAUSED when Halt = 1.
REQ-027 In RUN with Halt = 1, no instruction SHALL issue in that cycle.
REQ-028 PAUSED SHALL issue exactly one instruction per Step pulse when the FIFO is non-empty; Step with an empty FIFO SHALL be ignored.
REQ-029 PAUSED SHALL return to RUN or IDLE one cycle after Halt falls.
REQ-030 Step outside PAUSED SHALL be ignored.
REQ-031 Issue cycle: WEN, RW, RX, RY, Sel, Ctrl and DataIn SHALL be registered outputs driven from the FIFO head for exactly one cycle.
REQ-032 In every non-issue cycle, WEN SHALL be 0 and the other datapath outputs SHALL hold their last value.
REQ-033 Issue latency: an instruction accepted into an empty FIFO in RUN SHALL appear on the datapath outputs 2 cycles after acceptance.
REQ-034 Capture: for an issued instruction with Cap = 1, busY and Carry SHALL be sampled during its issue cycle and presented on Res_data and Res_carry, with Res_valid high, in the following cycle.
REQ-035 Res_data and Res_carry SHALL hold their value until the next capture.
REQ-036 Simultaneous accept and issue with a full FIFO SHALL NOT be possible (Inst_ready = 0); with a non-full FIFO both SHALL take effect and the occupancy SHALL be unchanged.
REQ-037 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-038 Issue_cnt SHALL increment on each issue and wrap modulo 256.

Reset
REQ-039 Rst_n low SHALL asynchronously force: state IDLE, FIFO empty, Inst_ready 1, WEN 0, RW/RX/RY 0, Sel 0, Ctrl 0, DataIn 0, Res_valid 0, Res_data 0, Res_carry 0, Issue_cnt 0, Busy 0.
REQ-040 Reset asserted mid-operation SHALL discard all buffered instructions, and no write SHALL reach the datapath after reset asserts.

Structure
REQ-041 A shared package SHALL hold the state encoding, the instruction field bit positions, and the 24-bit instruction width constant.
REQ-042 The FIFO SHALL be one sub-module, calc_inst_fifo (synchronous FIFO with full, empty and count outputs); the FSM, issue registers and capture logic SHALL reside in calc_sequencer.

Verification
REQ-043 Reset, then push {Ctrl=0, Sel=0, Wen=1, RW=3, Imm=0x5A} -> WEN=1, RW=3, DataIn=0x5A, Sel=0 for one cycle, 2 cycles after acceptance; Issue_cnt=1.
REQ-044 Push 5 instructions back-to-back with FIFO_DEPTH=4 while Halt=1 -> Inst_ready low after the 4th acceptance; 5th accepted after the first Step.
REQ-045 Halt=1 with 3 queued, then 2 Step pulses -> exactly 2 WEN pulses; Halt=0 -> 3rd issues; state returns to IDLE and Busy=0.
REQ-046 Cap=1 instruction with model busY=0xC3, Carry=1 in its issue cycle -> Res_valid pulse next cycle, Res_data=0xC3, Res_carry=1.
REQ-047 Issue 257 instructions -> Issue_cnt=1; FIFO pointers wrap with correct order (check RW sequence 0..7 repeating).
REQ-048 Assert Rst_n low during the issue stream -> WEN=0 immediately, FIFO empty, no issue after release until a new push.

Source files
------------

// File: rtl/calc_sequencer_pkg.sv
// Shared definitions for the calculator instruction sequencer: sequencer
// states, the 24-bit instruction width and the instruction field positions.
package calc_sequencer_pkg;

  localparam int INST_W = 24;

  localparam int CTRL_MSB = 23;
  localparam int CTRL_LSB = 20;
  localparam int SEL_BIT  = 19;
  localparam int WEN_BIT  = 18;
  localparam int RW_MSB   = 17;
  localparam int RW_LSB   = 15;
  localparam int RX_MSB   = 14;
  localparam int RX_LSB   = 12;
  localparam int RY_MSB   = 11;
  localparam int RY_LSB   = 9;
  localparam int CAP_BIT  = 8;
  localparam int IMM_MSB  = 7;
  localparam int IMM_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } seq_state_t;

endpackage

// File: rtl/calc_inst_fifo.sv
// Synchronous instruction FIFO with full/empty/count status; the head entry is
// visible combinationally on rdata so the sequencer can issue from it directly.
module calc_inst_fifo
  import calc_sequencer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = INST_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/calc_sequencer.sv
// Buffers instruction words and issues them to the calculator datapath one per
// cycle, with halt/single-step control and optional capture of busY/Carry.
module calc_sequencer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_valid,
  input  logic [23:0] inst,
  output logic        inst_ready,
  input  logic        halt,
  input  logic        step,
  output logic        wen,
  output logic [2:0]  rw,
  output logic [2:0]  rx,
  output logic [2:0]  ry,
  output logic        sel,
  output logic [3:0]  ctrl,
  output logic [7:0]  data_in,
  input  logic [7:0]  bus_y,
  input  logic        carry,
  output logic        res_valid,
  output logic [7:0]  res_data,
  output logic        res_carry,
  output logic [7:0]  issue_cnt,
  output logic        busy
);

  import calc_sequencer_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [INST_W-1:0] head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  seq_state_t        state;
  seq_state_t        state_next;
  logic              issue;
  logic              cap_pending;

  calc_inst_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (INST_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inst_valid),
    .pop   (issue),
    .wdata (inst),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign inst_ready = !fifo_full;
  assign busy       = (fifo_count != '0) || (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Halt always wins over issuing; a paused sequencer only issues on a step.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (halt)             state_next = ST_PAUSED;
        else if (!fifo_empty) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (halt)            state_next = ST_PAUSED;
        else if (fifo_empty) state_next = ST_IDLE;
        else                 issue      = 1'b1;
      end
      ST_PAUSED: begin
        issue = step && !fifo_empty;
        if (!halt) state_next = fifo_empty ? ST_IDLE : ST_RUN;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen         <= 1'b0;
      rw          <= '0;
      rx          <= '0;
      ry          <= '0;
      sel         <= 1'b0;
      ctrl        <= '0;
      data_in     <= '0;
      issue_cnt   <= '0;
      cap_pending <= 1'b0;
    end else begin
      wen         <= issue && head[WEN_BIT];
      cap_pending <= issue && head[CAP_BIT];
      if (issue) begin
        rw        <= head[RW_MSB:RW_LSB];
        rx        <= head[RX_MSB:RX_LSB];
        ry        <= head[RY_MSB:RY_LSB];
        sel       <= head[SEL_BIT];
        ctrl      <= head[CTRL_MSB:CTRL_LSB];
        data_in   <= head[IMM_MSB:IMM_LSB];
        issue_cnt <= issue_cnt + 8'd1;
      end
    end
  end

  // busY/Carry are sampled at the end of the issue cycle of a capturing
  // instruction, so the datapath has a full cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_carry <= 1'b0;
    end else begin
      res_valid <= cap_pending;
      if (cap_pending) begin
        res_data  <= bus_y;
        res_carry <= carry;
      end
    end
  end

endmodule
